// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared constants for the FIFO-fed UART transmitter.
// State encoding, parity modes and the parity helper.
package fifo_uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_FETCH  = S_FETCH,
    ST_WAIT   = S_WAIT,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic logic par_bit(
    input logic [7:0] d,
    input int         mode
  );
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// uart_baud_gen: bit-period counter for the UART transmitter.
// bit_tick marks the last cycle of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CW           = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  output logic          bit_tick,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..CLKS_PER_BIT-1, wrap on every bit boundary, hold 0 while cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_tick = (r_cnt == LAST) && !clear;
  assign count    = r_cnt;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and sends them as UART frames.
// Start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_enable,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_t     r_state;
  logic [7:0] r_shift;
  logic       r_par;
  logic [2:0] r_bit_idx;
  logic       r_stop_cnt;
  logic       r_tx;
  logic       r_busy;
  logic       r_rd;
  logic       r_done;

  logic          w_tick;
  logic [CW-1:0] w_count;
  logic          w_baud_clr;
  logic          w_start;
  logic          w_stop_last;

  assign w_start     = enable && !fifo_empty;
  assign w_stop_last = (r_stop_cnt == STOP_LAST);
  assign w_baud_clr  = (r_state == ST_IDLE) ||
                       (r_state == ST_FETCH) ||
                       (r_state == ST_WAIT);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) u_baud (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_baud_clr),
    .bit_tick(w_tick),
    .count   (w_count)
  );

  // Frame sequencer with registered line, strobe and status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_rd       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_start) begin
            r_state <= ST_FETCH;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_shift    <= fifo_data;
          r_par      <= par_bit(fifo_data, PARITY);
          r_bit_idx  <= '0;
          r_stop_cnt <= 1'b0;
          r_tx       <= 1'b0;
          r_state    <= ST_START;
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                r_tx    <= r_par;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_stop_last && (w_count == PRE_LAST)) begin
            r_done <= 1'b1;
          end
          if (w_tick) begin
            if (w_stop_last) begin
              r_stop_cnt <= 1'b0;
              if (w_start) begin
                r_state <= ST_FETCH;
                r_rd    <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx               = r_tx;
  assign busy             = r_busy;
  assign fifo_read_enable = r_rd;
  assign frame_done       = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed tests for fifo_uart_tx, CLKS_PER_BIT = 4.
// Four instances cover the parity and stop-bit configurations.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] en;
  logic [3:0] empty;
  logic [3:0] rd;
  logic [3:0] txl;
  logic [3:0] busy;
  logic [3:0] done;
  logic [7:0] fdata [4];
  logic [7:0] mem [4][16];
  int         wp [4] = '{0, 0, 0, 0};

  int checks = 0;
  int errors = 0;

  logic cap_tx [128];
  logic cap_dn [128];
  logic cap_bs [128];
  logic cap_rd [128];
  logic exp_tx [128];

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clock(clk), .reset_n(rst_n), .enable(en[0]),
    .fifo_empty(empty[0]), .fifo_data(fdata[0]),
    .fifo_read_enable(rd[0]), .tx(txl[0]),
    .busy(busy[0]), .frame_done(done[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
    .clock(clk), .reset_n(rst_n), .enable(en[1]),
    .fifo_empty(empty[1]), .fifo_data(fdata[1]),
    .fifo_read_enable(rd[1]), .tx(txl[1]),
    .busy(busy[1]), .frame_done(done[1])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (
    .clock(clk), .reset_n(rst_n), .enable(en[2]),
    .fifo_empty(empty[2]), .fifo_data(fdata[2]),
    .fifo_read_enable(rd[2]), .tx(txl[2]),
    .busy(busy[2]), .frame_done(done[2])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u3 (
    .clock(clk), .reset_n(rst_n), .enable(en[3]),
    .fifo_empty(empty[3]), .fifo_data(fdata[3]),
    .fifo_read_enable(rd[3]), .tx(txl[3]),
    .busy(busy[3]), .frame_done(done[3])
  );

  // FIFO models: data_out valid the cycle after a pop
  for (genvar g = 0; g < 4; g++) begin : g_fifo
    int rp = 0;
    assign empty[g] = (wp[g] == rp);
    always @(posedge clk) begin
      if (rd[g]) begin
        fdata[g] <= mem[g][rp[3:0]];
        rp <= rp + 1;
      end
    end
  end

  task automatic push(input int g, input logic [7:0] b);
    mem[g][wp[g][3:0]] = b;
    wp[g] = wp[g] + 1;
  endtask

  task automatic wait_pop(input int g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd[g]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic capture(input int g, input int off, input int n);
    for (int i = off; i < off + n; i++) begin
      @(negedge clk);
      cap_tx[i] = txl[g];
      cap_dn[i] = done[g];
      cap_bs[i] = busy[g];
      cap_rd[i] = rd[g];
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 128; i++) exp_tx[i] = 1'b1;
  endtask

  function automatic int build(
    input logic [7:0] b,
    input bit         has_par,
    input logic       pbit,
    input int         stops,
    input int         off
  );
    int k;
    k = off;
    for (int j = 0; j < 4; j++) begin
      exp_tx[k] = 1'b0;
      k = k + 1;
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp_tx[k] = b[i];
        k = k + 1;
      end
    end
    if (has_par) begin
      for (int j = 0; j < 4; j++) begin
        exp_tx[k] = pbit;
        k = k + 1;
      end
    end
    for (int j = 0; j < stops * 4; j++) begin
      exp_tx[k] = 1'b1;
      k = k + 1;
    end
    return k;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    en = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (txl !== 4'hF) begin
      errors++;
      $display("FAIL reset_tx: got %b want 1111", txl);
    end
    checks++;
    if (busy !== 4'h0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0000", busy);
    end
    checks++;
    if (rd !== 4'h0) begin
      errors++;
      $display("FAIL reset_rd: got %b want 0000", rd);
    end
    checks++;
    if (done !== 4'h0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0000", done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_a5();
    bit ok;
    int mm;
    int nd;
    int nr;
    en[0] = 1'b1;
    push(0, 8'hA5);
    wait_pop(0, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL a5_pop: got %b want 1", ok);
    end
    capture(0, 0, 42);
    clear_exp();
    void'(build(8'hA5, 1'b0, 1'b0, 1, 1));
    mm = 0;
    nd = 0;
    nr = 0;
    for (int i = 0; i < 42; i++) begin
      if (cap_tx[i] !== exp_tx[i]) mm++;
      if (cap_dn[i] === 1'b1) nd++;
      if (cap_rd[i] === 1'b1) nr++;
    end
    checks++;
    if (mm != 0) begin
      errors++;
      $display("FAIL a5_tx: %0d bad cycles, want 0", mm);
    end
    checks++;
    if (cap_dn[40] !== 1'b1 || nd != 1) begin
      errors++;
      $display("FAIL a5_done: at40=%b pulses=%0d want 1,1",
               cap_dn[40], nd);
    end
    checks++;
    if (nr != 0) begin
      errors++;
      $display("FAIL a5_pops: extra=%0d want 0", nr);
    end
    checks++;
    if (cap_bs[40] !== 1'b1 || cap_bs[41] !== 1'b0) begin
      errors++;
      $display("FAIL a5_busy: %b%b want 10", cap_bs[40], cap_bs[41]);
    end
  endtask

  task automatic test_idle();
    int nr;
    int nt;
    int nb;
    nr = 0;
    nt = 0;
    nb = 0;
    en[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd[0] !== 1'b0) nr++;
      if (txl[0] !== 1'b1) nt++;
      if (busy[0] !== 1'b0) nb++;
    end
    checks++;
    if (nr != 0) begin
      errors++;
      $display("FAIL empty_pop: %0d pops want 0", nr);
    end
    checks++;
    if (nt != 0) begin
      errors++;
      $display("FAIL empty_tx: %0d low cycles want 0", nt);
    end
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL empty_busy: %0d busy cycles want 0", nb);
    end
    en[0] = 1'b0;
    push(0, 8'hF0);
    nr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd[0] !== 1'b0) nr++;
    end
    checks++;
    if (nr != 0) begin
      errors++;
      $display("FAIL disabled_pop: %0d pops want 0", nr);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nr;
    int nb;
    en[0] = 1'b1;
    wait_pop(0, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_pop: got %b want 1", ok);
    end
    capture(0, 0, 18);
    checks++;
    if (cap_tx[17] !== 1'b0 || cap_bs[17] !== 1'b1) begin
      errors++;
      $display("FAIL rst_bit3: tx=%b busy=%b want 0,1",
               cap_tx[17], cap_bs[17]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (txl[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: tx=%b busy=%b want 1,0",
               txl[0], busy[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nr = 0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd[0] !== 1'b0) nr++;
      if (busy[0] !== 1'b0 || txl[0] !== 1'b1) nb++;
    end
    checks++;
    if (nr != 0 || nb != 0) begin
      errors++;
      $display("FAIL rst_idle: pops=%0d active=%0d want 0,0", nr, nb);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int mm;
    int nd;
    int nr;
    push(0, 8'h11);
    push(0, 8'h22);
    en[0] = 1'b1;
    wait_pop(0, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL drop_pop: got %b want 1", ok);
    end
    capture(0, 0, 10);
    en[0] = 1'b0;
    capture(0, 10, 50);
    clear_exp();
    void'(build(8'h11, 1'b0, 1'b0, 1, 1));
    mm = 0;
    nd = 0;
    nr = 0;
    for (int i = 0; i < 60; i++) begin
      if (cap_tx[i] !== exp_tx[i]) mm++;
      if (cap_dn[i] === 1'b1) nd++;
      if (cap_rd[i] === 1'b1) nr++;
    end
    checks++;
    if (mm != 0) begin
      errors++;
      $display("FAIL drop_tx: %0d bad cycles, want 0", mm);
    end
    checks++;
    if (cap_dn[40] !== 1'b1 || nd != 1) begin
      errors++;
      $display("FAIL drop_done: at40=%b pulses=%0d want 1,1",
               cap_dn[40], nd);
    end
    checks++;
    if (nr != 0 || cap_bs[45] !== 1'b0) begin
      errors++;
      $display("FAIL drop_nopop: pops=%0d busy=%b want 0,0",
               nr, cap_bs[45]);
    end
  endtask

  task automatic test_parity(input int g, input logic pbit);
    bit ok;
    int mm;
    int nd;
    en[g] = 1'b1;
    push(g, 8'h07);
    wait_pop(g, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL par%0d_pop: got %b want 1", g, ok);
    end
    capture(g, 0, 46);
    clear_exp();
    void'(build(8'h07, 1'b1, pbit, 1, 1));
    mm = 0;
    nd = 0;
    for (int i = 0; i < 46; i++) begin
      if (cap_tx[i] !== exp_tx[i]) mm++;
      if (cap_dn[i] === 1'b1) nd++;
    end
    checks++;
    if (cap_tx[38] !== pbit) begin
      errors++;
      $display("FAIL par%0d_bit: got %b want %b", g, cap_tx[38], pbit);
    end
    checks++;
    if (mm != 0) begin
      errors++;
      $display("FAIL par%0d_tx: %0d bad cycles, want 0", g, mm);
    end
    checks++;
    if (cap_dn[44] !== 1'b1 || nd != 1 || cap_bs[45] !== 1'b0) begin
      errors++;
      $display("FAIL par%0d_len: done44=%b pulses=%0d busy45=%b",
               g, cap_dn[44], nd, cap_bs[45]);
    end
    en[g] = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int mm;
    int nd;
    int nr;
    int nb;
    en[3] = 1'b1;
    push(3, 8'h55);
    push(3, 8'h0F);
    wait_pop(3, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pop: got %b want 1", ok);
    end
    capture(3, 0, 95);
    clear_exp();
    void'(build(8'h55, 1'b0, 1'b0, 2, 1));
    void'(build(8'h0F, 1'b0, 1'b0, 2, 47));
    mm = 0;
    nd = 0;
    nr = 0;
    nb = 0;
    for (int i = 0; i < 95; i++) begin
      if (cap_tx[i] !== exp_tx[i]) mm++;
      if (cap_dn[i] === 1'b1) nd++;
      if (cap_rd[i] === 1'b1) nr++;
      if (i <= 90 && cap_bs[i] !== 1'b1) nb++;
    end
    checks++;
    if (mm != 0) begin
      errors++;
      $display("FAIL b2b_tx: %0d bad cycles, want 0", mm);
    end
    checks++;
    if (cap_tx[45] !== 1'b1 || cap_tx[46] !== 1'b1 ||
        cap_tx[47] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: %b%b%b want 110",
               cap_tx[45], cap_tx[46], cap_tx[47]);
    end
    checks++;
    if (nr != 1 || cap_rd[45] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pops: second=%0d at45=%b want 1,1",
               nr, cap_rd[45]);
    end
    checks++;
    if (nd != 2 || cap_dn[44] !== 1'b1 || cap_dn[90] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d at44=%b at90=%b want 2,1,1",
               nd, cap_dn[44], cap_dn[90]);
    end
    checks++;
    if (nb != 0 || cap_bs[91] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: gaps=%0d busy91=%b want 0,0",
               nb, cap_bs[91]);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_idle();
    test_reset_mid();
    test_enable_drop();
    test_parity(1, 1'b1);
    test_parity(2, 1'b0);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains bytes from the read side of a `fifo_buffer` and transmits each one as an asynchronous serial (UART) frame on a single `tx` line. It sits downstream of the FIFO: the producer writes bytes into the FIFO, and this block pops one byte whenever the FIFO is non-empty and the line is idle. Frame format is start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clock`, input, 1: single clock; all logic is rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: permits starting a new frame.
- `fifo_empty`, input, 1: FIFO `empty` flag.
- `fifo_data`, input, 8: FIFO `data_out`; valid the cycle after `fifo_read_enable`.
- `fifo_read_enable`, output, 1: FIFO pop strobe; one-cycle pulse per byte.
- `tx`, output, 1: serial line; idles high.
- `busy`, output, 1: high in every state except IDLE.
- `frame_done`, output, 1: one-cycle pulse at the end of the last stop bit.

## Operation
- States: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - `enable && !fifo_empty` → FETCH.
  - Otherwise stay in IDLE with `tx = 1`.
- FETCH: `fifo_read_enable = 1` for exactly this cycle → WAIT. This state is never skipped.
- WAIT: on the closing edge, perform all of the following, then → START.
  - Capture `fifo_data` into the shift register.
  - Compute the parity bit: even = `^data`, odd = `~^data`.
  - Drive `tx` low.
- START: hold `tx = 0` for `CLKS_PER_BIT` cycles → DATA.
- DATA: send 8 bits LSB-first, each held `CLKS_PER_BIT` cycles. A 3-bit counter tracks the bit index. After bit 7:
  - → PARITY if `PARITY != 0`.
  - → STOP otherwise.
- PARITY: hold the parity bit for `CLKS_PER_BIT` cycles → STOP.
- STOP: `tx = 1` for `STOP_BITS*CLKS_PER_BIT` cycles.
  - `frame_done` pulses in the final cycle of STOP.
  - Next state is FETCH if `enable && !fifo_empty`, otherwise IDLE.
- `enable` deasserted mid-frame: the current frame completes; no new frame starts.
- `fifo_empty` is sampled only in IDLE and in the last STOP cycle. The block never pops an empty FIFO.
- Reset asserted at any time: all outputs go to their reset values immediately. A byte that was already popped is discarded.
- Reset values: `tx = 1`, `busy = 0`, `fifo_read_enable = 0`, `frame_done = 0`, state IDLE, all counters 0.
- Widths:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits. It counts 0..`CLKS_PER_BIT-1` and reloads to 0 on every bit boundary.
  - Stop counter counts `STOP_BITS` bit periods.

## Timing
- All outputs are registered and glitch-free.
- `tx` is never combinational.
- Start-up latency: `fifo_empty` falls with `enable` high, sampled at edge E0.
  - `fifo_read_enable` is high in cycle E0..E1.
  - `tx` falls after edge E2.
- Frame length: (1 + 8 + (PARITY?1:0) + STOP_BITS) × `CLKS_PER_BIT` cycles.
- Back-to-back frames: exactly 2 idle-high cycles (FETCH, WAIT) follow the last stop bit before the next start bit.
- `busy` rises in the FETCH cycle and falls in the cycle after `frame_done`, unless the next frame follows directly.

## Structure
- Shared package `fifo_uart_pkg` holds:
  - State encoding localparams (3-bit).
  - Parity mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
- Sub-module `uart_baud_gen`: counter with `clear` input and `bit_tick` output (high on the last cycle of each bit period). Instantiated once.
- The FSM, shift register, bit counter and parity generator live in `fifo_uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT = 4`.
- `PARITY = 0`, FIFO preloaded with 0xA5 → `tx` = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles. One `fifo_read_enable` pulse, one `frame_done` pulse, 40 cycles from START to the end of STOP.
- `PARITY = 1`, byte 0x07 → parity bit 1. `PARITY = 2`, same byte → parity bit 0. Frame is 44 cycles.
- Two bytes 0x55, 0x0F queued, `STOP_BITS = 2` → 2 high cycles between the end of the first stop period and the second start bit. Second byte transmitted correctly. Exactly 2 pop pulses.
- FIFO empty with `enable = 1` for 50 cycles → `fifo_read_enable` never asserted, `tx = 1`, `busy = 0`. Byte present with `enable = 0` → no pop.
- `reset_n` pulled low during DATA bit 3 → `tx = 1` and `busy = 0` in the same cycle. After release with an empty FIFO, the block stays in IDLE.
- `enable` dropped during DATA with a second byte queued → first frame completes, `frame_done` pulses, second byte not popped.
